// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: streams bytes from synchronous program RAM, packs them into instruction words and queues them.
// Define FETCH_PERF_EN to add saturating pop/stall/flush counters.
module instr_fetch_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int INSTR_BYTES = 3,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            mem_rd_en,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic [DATA_W-1:0]               mem_data,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic [DATA_W*INSTR_BYTES-1:0]   instr_word,
  output logic [ADDR_W-1:0]               instr_pc,
  input  logic                            redirect,
  input  logic [ADDR_W-1:0]               redirect_pc,
  input  logic                            halt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]                     perf_instr_count,
  output logic [15:0]                     perf_stall_cycles,
  output logic [15:0]                     perf_flush_count
`endif
);
  localparam int W = DATA_W * INSTR_BYTES;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int BC_W = INSTR_BYTES > 1 ? $clog2(INSTR_BYTES) : 1;
  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, rd_addr_q, asm_pc_q;
  logic [BC_W-1:0] iss_cnt_q, land_cnt_q;
  logic inflight_q, pending_q;
  logic [W-1:0] asm_q, word_d;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [W-1:0] fifo_word [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc [FIFO_DEPTH];
  logic credit_ok, issue, land, last, push, pop;
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction
  // Credit only gates the first byte; later bytes already own the slot reserved by pending_q.
  assign credit_ok = (iss_cnt_q != '0) ||
                     (({1'b0, count_q} + (CNT_W+1)'(pending_q)) < (CNT_W+1)'(FIFO_DEPTH));
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = halt ? HALT : (credit_ok ? RUN : STALL);
      STALL:   state_d = halt ? HALT : (credit_ok ? RUN : STALL);
      default: state_d = halt ? HALT : (credit_ok ? RUN : STALL);
    endcase
  end
  assign issue = rst && !redirect && (state_d == RUN);
  assign mem_rd_en = issue;
  assign mem_addr = pc_q;
  assign land = inflight_q && !redirect;
  assign last = land_cnt_q == BC_W'(INSTR_BYTES - 1);
  assign push = land && last;
  assign instr_valid = count_q != '0;
  assign pop = instr_valid && instr_ready && !redirect;
  assign word_d = ((land_cnt_q == '0 ? '0 : asm_q) << DATA_W) | W'(mem_data);
  assign instr_word = instr_valid ? fifo_word[rd_ptr_q] : '0;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      rd_addr_q <= '0;
      asm_pc_q <= '0;
      iss_cnt_q <= '0;
      land_cnt_q <= '0;
      inflight_q <= 1'b0;
      pending_q <= 1'b0;
      asm_q <= '0;
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      inflight_q <= issue;
      rd_addr_q <= pc_q;
      if (redirect) begin
        pc_q <= redirect_pc;
        iss_cnt_q <= '0;
        land_cnt_q <= '0;
        pending_q <= 1'b0;
        count_q <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (issue) begin
          pc_q <= pc_q + ADDR_W'(1);
          iss_cnt_q <= (iss_cnt_q == BC_W'(INSTR_BYTES - 1)) ? '0 : iss_cnt_q + BC_W'(1);
        end
        pending_q <= (issue && iss_cnt_q == '0) || (pending_q && !push);
        if (land) begin
          land_cnt_q <= last ? '0 : land_cnt_q + BC_W'(1);
          asm_q <= word_d;
          if (land_cnt_q == '0) asm_pc_q <= rd_addr_q;
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_q <= nxt(wr_ptr_q);
        if (pop) rd_ptr_q <= nxt(rd_ptr_q);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr_q] <= word_d;
      fifo_pc[wr_ptr_q] <= (land_cnt_q == '0) ? rd_addr_q : asm_pc_q;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_instr_count <= '0;
      perf_stall_cycles <= '0;
      perf_flush_count <= '0;
    end else begin
      perf_instr_count <= perf_instr_count + 16'(pop && perf_instr_count != '1);
      perf_stall_cycles <= perf_stall_cycles + 16'(state_q == STALL && perf_stall_cycles != '1);
      perf_flush_count <= perf_flush_count + 16'(redirect && perf_flush_count != '1);
    end
  end
`endif
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised successor to the fixed PC/MAR/IR fetch chain. Streams bytes from synchronous program RAM, packs INSTR_BYTES bytes into one instruction word, and buffers complete words in a small FIFO.
- The control unit consumes instructions through a valid/ready handshake.
- Supports PC redirect (jump/branch) with flush, a halt input, and any instruction length or bus width.

Parameters:
- DATA_W, 8, RAM data width in bits.
- ADDR_W, 8, program address width; PC wraps modulo 2^ADDR_W.
- INSTR_BYTES, 3, RAM words per instruction (>=1).
- FIFO_DEPTH, 2, number of complete instructions buffered (>=1).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_data  in  DATA_W  RAM read data, valid the cycle after mem_rd_en.
- instr_valid  out  1  FIFO head holds a complete instruction.
- instr_ready  in  1  consumer accepts the head this cycle.
- instr_word  out  DATA_W*INSTR_BYTES  head instruction; first-fetched byte in the MSBs.
- instr_pc  out  ADDR_W  address of the first byte of the head instruction.
- redirect  in  1  load a new PC and flush.
- redirect_pc  in  ADDR_W  target PC.
- halt  in  1  suppress new RAM reads.
- fifo_count  out  clog2(FIFO_DEPTH+1)  number of buffered instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_rd_en=0, mem_addr=RESET_PC, instr_valid=0, instr_word=0, instr_pc=0, fifo_count=0.
  - Byte counter=0, in-flight flag=0, state=RUN.
- Read timing: a read issued in cycle N (mem_rd_en=1, mem_addr=PC) is sampled from mem_data at the end of cycle N+1. At most one byte per cycle. PC increments by 1 per issued byte and wraps from 2^ADDR_W-1 to 0.
- Assembly:
  - A byte counter 0..INSTR_BYTES-1 tracks the byte position in the current instruction.
  - The PC of byte 0 is latched as the instruction PC.
  - The last byte and the pushed word land at the same edge, so instr_valid is high one cycle after that edge.
- Credit rule: a read may issue only when fifo_count + asm_pending < FIFO_DEPTH and halt=0 and redirect=0.
  - asm_pending=1 from issue of byte 0 until that instruction is pushed.
  - A same-cycle pop does not relax the check; this costs a one-cycle bubble when full and guarantees no overflow.
- FSM:
  - RUN: issuing reads.
  - STALL: credit check fails; go to RUN when the credit frees.
  - HALT: halt=1; go to RUN or STALL when halt=0.
  - Bytes already in flight still land and push in every state.
- Handshake:
  - A pop occurs when instr_valid and instr_ready are both high.
  - instr_word and instr_pc are stable while instr_valid=1 and instr_ready=0.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Redirect (highest priority):
  - In the redirect cycle: FIFO cleared, byte counter reset, PC<=redirect_pc, and no read issued.
  - The returning in-flight byte is discarded.
  - instr_valid=0 in the following cycle; the first read from redirect_pc issues in that following cycle.
  - A pop coincident with redirect is discarded.
- Redirect and halt together: the PC loads, and no reads issue until halt=0.
- Reset mid-assembly: the partial word is dropped; the next read is RESET_PC after rst=1.
- Startup timing with INSTR_BYTES=3: after rst rises, reads issue in cycles 0, 1, 2 and instr_valid=1 in cycle 4.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three 16-bit saturating outputs, all reset to 0 and each incrementing by 1 per event:
  - perf_instr_count: instructions popped.
  - perf_stall_cycles: cycles in STALL.
  - perf_flush_count: redirects.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Defaults; RAM[0..5]=01,02,03,04,05,06; instr_ready=1 held -> cycle 4: instr_word=010203, instr_pc=00; cycle 7: instr_word=040506, instr_pc=03.
- instr_ready=0 held -> fifo_count reaches 2; mem_rd_en=0 thereafter; no overflow; head stays 010203/00 until ready.
- redirect=1, redirect_pc=0x40 while byte 1 of an instruction is in flight -> FIFO empties; next mem_addr=0x40; first delivered instr_pc=0x40; the stale byte never appears in any word.
- Start at RESET_PC=0xFE, RAM[FE]=AA, RAM[FF]=BB, RAM[00]=CC -> instr_word=AABBCC, instr_pc=FE; next instr_pc=01.
- halt=1 for 5 cycles mid-stream -> mem_rd_en=0 during halt; in-flight byte still captured; stream resumes at the correct PC with no byte lost.
- rst pulsed low mid-assembly -> all outputs at reset values immediately; refetch from RESET_PC; with FETCH_PERF_EN, counters read 0.
